// File: rtl/decrypt_aes_ecb_if.sv
// Block handshake bundle for the AES-128 ECB decryption core.
// The master drives ciphertext requests; the slave returns plaintext with a one-cycle valid pulse.
interface decrypt_aes_ecb_if;
    logic         enable_i;
    logic         process_start_i;
    logic         busy_o;
    logic [127:0] bytes_i;
    logic [127:0] bytes_o;
    logic         bytes_valid_o;

    modport master (
        output enable_i, process_start_i, bytes_i,
        input  busy_o, bytes_o, bytes_valid_o
    );

    modport slave (
        input  enable_i, process_start_i, bytes_i,
        output busy_o, bytes_o, bytes_valid_o
    );
endinterface

// File: rtl/decrypt_aes_ecb.sv
// Iterative AES-128 ECB decryption, one inverse round per clock, fixed key.
// Round keys are expanded forward once after reset, then consumed from rk10 down to rk0.
module decrypt_aes_ecb #(
    parameter logic [127:0] KEY        = 128'h0f0e0d0c0b0a09080706050403020100,
    parameter int           DATA_WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    decrypt_aes_ecb_if.slave  bus
);
    localparam int NB = 128 / DATA_WIDTH;

    typedef enum logic [1:0] {KEYGEN, IDLE, ROUND} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic [127:0] data_q, data_d;
    logic [127:0] out_q, out_d;
    logic [127:0] rk_q [1:10];
    logic [127:0] rk_d [1:10];
    logic [127:0] rk_all [0:10];
    logic [127:0] rk_sel;
    logic [127:0] key_next;
    logic [127:0] ark_state;
    logic [127:0] mix_state;
    logic [127:0] round_out;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;

    assign rk_all[0] = KEY;

    for (genvar gi = 1; gi <= 10; gi++) begin : g_rk
        assign rk_all[gi] = rk_q[gi];
        assign rk_d[gi]   = (state_q == KEYGEN && cnt_q == 4'(gi - 1)) ? key_next : rk_q[gi];
        always_ff @(posedge clk_i) begin
            rk_q[gi] <= rk_d[gi];
        end
    end

    // cnt_q names the current key: source key during KEYGEN, round key during ROUND.
    always_comb begin
        rk_sel = KEY;
        for (int i = 0; i < 11; i++) begin
            if (cnt_q == 4'(i)) rk_sel = rk_all[i];
        end
    end

    assign rot_word = {rk_sel[103:96], rk_sel[127:104]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        assign sub_word[DATA_WIDTH*gi +: DATA_WIDTH] = sbox(rot_word[DATA_WIDTH*gi +: DATA_WIDTH]);
    end

    assign key_next[31:0]   = rk_sel[31:0]   ^ sub_word ^ {24'h000000, rcon(cnt_q)};
    assign key_next[63:32]  = rk_sel[63:32]  ^ key_next[31:0];
    assign key_next[95:64]  = rk_sel[95:64]  ^ key_next[63:32];
    assign key_next[127:96] = rk_sel[127:96] ^ key_next[95:64];

    // Byte gi sits at row gi%4, column gi/4; InvShiftRows pulls row r from column c-r.
    for (genvar gi = 0; gi < NB; gi++) begin : g_round
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
        localparam int B1  = 4 * COL + (ROW + 1) % 4;
        localparam int B2  = 4 * COL + (ROW + 2) % 4;
        localparam int B3  = 4 * COL + (ROW + 3) % 4;

        assign ark_state[DATA_WIDTH*gi +: DATA_WIDTH] =
            inv_sbox(data_q[DATA_WIDTH*SRC +: DATA_WIDTH]) ^ rk_sel[DATA_WIDTH*gi +: DATA_WIDTH];

        assign mix_state[DATA_WIDTH*gi +: DATA_WIDTH] =
            gf_mul(8'h0e, ark_state[DATA_WIDTH*gi +: DATA_WIDTH]) ^
            gf_mul(8'h0b, ark_state[DATA_WIDTH*B1 +: DATA_WIDTH]) ^
            gf_mul(8'h0d, ark_state[DATA_WIDTH*B2 +: DATA_WIDTH]) ^
            gf_mul(8'h09, ark_state[DATA_WIDTH*B3 +: DATA_WIDTH]);
    end

    assign round_out = (cnt_q == 4'd0) ? ark_state : mix_state;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        data_d  = data_q;
        out_d   = out_q;
        valid_d = 1'b0;
        case (state_q)
            KEYGEN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            IDLE: begin
                if (bus.enable_i && bus.process_start_i && !busy_q) begin
                    data_d  = bus.bytes_i ^ rk_q[10];
                    cnt_d   = 4'd9;
                    busy_d  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (bus.enable_i) begin
                    data_d = round_out;
                    if (cnt_q == 4'd0) begin
                        out_d   = round_out;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = KEYGEN;
                cnt_d   = 4'd0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= KEYGEN;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.bytes_o       = out_q;
    assign bus.bytes_valid_o = valid_q;
endmodule

// File: tb/tb_decrypt_aes_ecb.sv
// Self-checking bench for decrypt_aes_ecb: FIPS-197 vector, model-checked random blocks,
// keygen timing, enable stalls, held requests, disabled idle and mid-operation reset.
module tb_decrypt_aes_ecb;
    localparam logic [127:0] KEY   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] C1_PT = 128'hffeeddccbbaa99887766554433221100;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
        int           stall_at;
        int           stall_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decrypt_aes_ecb_if bus ();

    decrypt_aes_ecb #(.KEY(KEY)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];
    logic [7:0] rkb     [11][16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- reference model (table S-box, byte-array state) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_model();
        logic [7:0] inv, s, rc, tmp;
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x] = s;
            isbox_t[s] = 8'(x);
        end
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = KEY[8*(4*i+j) +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[tmp];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int r = 0; r < 11; r++)
            for (int k = 0; k < 16; k++) rkb[r][k] = w[4*r + k/4][k%4];
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ rkb[0][k];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rkb[rnd][k];
        end
        for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k];
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = ct[8*k +: 8] ^ rkb[10][k];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+4-r)%4)+r];
            for (int k = 0; k < 16; k++) s[k] = isbox_t[t[k]] ^ rkb[rnd][k];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
        end
        for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k];
        return o;
    endfunction

    // One accepted block from IDLE, optionally with enable dropped for stall_len edges
    // starting after stall_at round edges.
    task automatic run_block(input string name, input vec_t v);
        int lat;
        bit got;
        bit busy_ok;
        check({name, "_idle_busy"}, 128'(bus.busy_o), 128'(1'b0));
        bus.enable_i        = 1'b1;
        bus.process_start_i = 1'b1;
        bus.bytes_i         = v.ct;
        tick();
        bus.process_start_i = 1'b0;
        bus.bytes_i         = rand128();
        check({name, "_busy_after_accept"}, 128'(bus.busy_o), 128'(1'b1));
        lat = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && lat < 60) begin
            if (v.stall_len > 0 && lat == v.stall_at) bus.enable_i = 1'b0;
            if (v.stall_len > 0 && lat == v.stall_at + v.stall_len) bus.enable_i = 1'b1;
            tick();
            lat++;
            if (bus.bytes_valid_o === 1'b1) got = 1'b1;
            else if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
        end
        bus.enable_i = 1'b1;
        check({name, "_busy_held"}, 128'(busy_ok), 128'(1'b1));
        check({name, "_latency"}, 128'(lat), 128'(10 + v.stall_len));
        check({name, "_bytes"}, bus.bytes_o, v.pt);
        check({name, "_busy_at_valid"}, 128'(bus.busy_o), 128'(1'b0));
        tick();
        check({name, "_valid_pulse_end"}, 128'(bus.bytes_valid_o), 128'(1'b0));
        check({name, "_bytes_hold"}, bus.bytes_o, v.pt);
    endtask

    initial begin
        vec_t         vecs [8];
        logic [127:0] pts [8];
        logic [127:0] cts [8];
        int           kg, lat, idx, nvalid, last, cyc;
        bit           seen_valid, acc, bad;
        vec_t         c1v;

        bus.enable_i        = 1'b1;
        bus.process_start_i = 1'b1;
        bus.bytes_i         = C1_CT;

        build_model();
        if (aes_dec(C1_CT) !== C1_PT || aes_enc(C1_PT) !== C1_CT) begin
            $display("FAIL model_c1: reference model disagrees with FIPS-197 C.1");
            $fatal(1);
        end

        vecs[0] = '{C1_CT, C1_PT, 0, 0};
        vecs[1] = '{C1_CT, C1_PT, 4, 3};
        for (int i = 2; i < 8; i++) begin
            vecs[i].ct        = rand128();
            vecs[i].pt        = aes_dec(vecs[i].ct);
            vecs[i].stall_at  = int'($urandom_range(0, 9));
            vecs[i].stall_len = (i < 5) ? 0 : int'($urandom_range(1, 3));
        end

        // Reset state, then KEYGEN with a request held from the start.
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'(bus.busy_o), 128'(1'b1));
        check("reset_valid", 128'(bus.bytes_valid_o), 128'(1'b0));
        check("reset_bytes", bus.bytes_o, 128'h0);
        rst_n = 1'b1;
        kg = 0;
        seen_valid = 1'b0;
        while (bus.busy_o === 1'b1 && kg < 30) begin
            tick();
            kg++;
            if (bus.bytes_valid_o === 1'b1) seen_valid = 1'b1;
        end
        check("keygen_busy_cycles", 128'(kg), 128'(10));
        check("keygen_no_valid", 128'(seen_valid), 128'(1'b0));
        tick();
        check("keygen_first_accept", 128'(bus.busy_o), 128'(1'b1));
        bus.process_start_i = 1'b0;
        lat = 0;
        while (bus.bytes_valid_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("keygen_c1_latency", 128'(lat), 128'(10));
        check("keygen_c1_bytes", bus.bytes_o, C1_PT);
        tick();

        for (int i = 0; i < 8; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i]);
        end

        // Disabled idle must not accept a request.
        bus.enable_i        = 1'b0;
        bus.process_start_i = 1'b1;
        bus.bytes_i         = C1_CT;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy_o !== 1'b0 || bus.bytes_valid_o !== 1'b0) bad = 1'b1;
        end
        check("disabled_idle_no_accept", 128'(bad), 128'(1'b0));
        bus.process_start_i = 1'b0;
        bus.enable_i        = 1'b1;
        tick();
        check("disabled_idle_still_idle", 128'(bus.busy_o), 128'(1'b0));

        // Round trip: held request, data advanced only on acceptance.
        for (int i = 0; i < 8; i++) begin
            pts[i] = rand128();
            cts[i] = aes_enc(pts[i]);
        end
        idx = 0;
        nvalid = 0;
        last = 0;
        cyc = 0;
        bus.process_start_i = 1'b1;
        bus.bytes_i         = cts[0];
        while (nvalid < 8 && cyc < 200) begin
            acc = (bus.busy_o === 1'b0) && (idx < 8);
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 8) bus.bytes_i = cts[idx];
                else bus.process_start_i = 1'b0;
            end
            if (bus.bytes_valid_o === 1'b1) begin
                check($sformatf("rt%0d_bytes", nvalid), bus.bytes_o, pts[nvalid]);
                if (nvalid > 0) check($sformatf("rt%0d_gap", nvalid), 128'(cyc - last), 128'(11));
                last = cyc;
                nvalid++;
            end
        end
        bus.process_start_i = 1'b0;
        check("rt_count", 128'(nvalid), 128'(8));
        tick();

        // Reset four cycles into a block: async clear, no pulse, KEYGEN reruns.
        bus.process_start_i = 1'b1;
        bus.bytes_i         = C1_CT;
        tick();
        bus.process_start_i = 1'b0;
        seen_valid = 1'b0;
        repeat (4) begin
            tick();
            if (bus.bytes_valid_o === 1'b1) seen_valid = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(bus.busy_o), 128'(1'b1));
        check("midrst_valid", 128'(bus.bytes_valid_o), 128'(1'b0));
        check("midrst_bytes", bus.bytes_o, 128'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        kg = 0;
        while (bus.busy_o === 1'b1 && kg < 30) begin
            tick();
            kg++;
            if (bus.bytes_valid_o === 1'b1) seen_valid = 1'b1;
        end
        check("midrst_keygen_cycles", 128'(kg), 128'(10));
        check("midrst_no_valid", 128'(seen_valid), 128'(1'b0));
        c1v = '{C1_CT, C1_PT, 0, 0};
        run_block("post_reset_c1", c1v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/decrypt_aes_ecb.md
Name: decrypt_aes_ecb

Overview:
- Iterative AES-128 ECB decryption core, one inverse round per clock, with a fixed key set by parameter.
- It is the receive-side counterpart of Encrypt_AES_ECB and uses the same start/busy/valid handshake and the same 128-bit byte packing.
- It expands the key forward once after reset and stores all 11 round keys, then applies them in reverse order.
- Inverse S-box and forward S-box (key expansion only) are shared lookup submodules; they are not counted in this block.

Parameters:
- KEY, 128'h0f0e0d0c0b0a09080706050403020100: cipher key in block packing (key byte 0 in [7:0]), i.e. FIPS-197 C.1 key 000102..0f.
- DATA_WIDTH, 8: byte width; fixed, not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  block enable; when 0 the FSM freezes (except KEYGEN).
- process_start_i  in  1  request: bytes_i holds a ciphertext block.
- busy_o  out  1  1 = cannot accept a block.
- bytes_i  in  128  ciphertext; byte k in [8k+7:8k], byte 0 = first byte of block.
- bytes_o  out  128  plaintext, same packing.
- bytes_valid_o  out  1  single-cycle pulse, bytes_o valid.

Behaviour:
- Reset (async, rst_n_i=0) values:
  - busy_o=1, bytes_o=0, bytes_valid_o=0.
  - State=KEYGEN, round counter=0.
  - Round-key registers: don't care; rk0 loads KEY.
- KEYGEN:
  - 10 cycles after reset release, computing rk1..rk10 (RotWord/SubWord/Rcon 01,02,..,36), one per edge.
  - Runs regardless of enable_i.
  - process_start_i is ignored; no buffering.
  - busy_o=1 throughout; on the edge storing rk10 the FSM goes to IDLE and busy_o falls.
- IDLE:
  - A block is accepted on a rising edge where enable_i=1, process_start_i=1 and busy_o=0 (edge E0).
  - At E0: state <= bytes_i ^ rk10, round r <= 9, busy_o <= 1.
- ROUND:
  - Edges E1..E10 perform rounds r=9..0: InvShiftRows, InvSubBytes, AddRoundKey rk[r], then InvMixColumns only if r!=0.
  - At E10: bytes_o <= result, bytes_valid_o <= 1, busy_o <= 0, FSM -> IDLE.
- Timing:
  - Latency is 10 clocks from acceptance edge to valid.
  - bytes_valid_o is high exactly one cycle, and busy_o is low in that same cycle.
  - The earliest next acceptance is E11, so throughput is 1 block per 11 cycles.
- bytes_o holds its last value until the next completion. bytes_valid_o is 0 in every cycle other than the completion cycle.
- enable_i=0 during ROUND:
  - The round counter and state register hold; no edges advance and busy_o stays 1.
  - Processing resumes on the first edge with enable_i=1.
  - Latency is extended by the number of disabled edges.
- enable_i=0 in IDLE: no acceptance, even if process_start_i=1.
- Held requests:
  - Upstream must hold process_start_i and bytes_i while busy_o=1.
  - A request while busy_o=1 is not captured and not lost; it is taken at the first edge with busy_o=0.
  - process_start_i held continuously with changing data yields one acceptance per 11 cycles.
- Reset mid-operation:
  - Asserting rst_n_i at any time aborts immediately to the reset values.
  - The in-flight block is discarded with no valid pulse; KEYGEN reruns.
- Bytes within a column map as standard AES: state column c = bytes 4c..4c+3, with row 0 = byte 4c.

Test Plan:
- KEYGEN timing: release reset and hold process_start_i=1 with any data -> busy_o=1 for exactly 10 cycles, no bytes_valid_o; the first acceptance happens on the edge where busy_o is 0.
- FIPS-197 C.1 vector:
  - Input ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, byte 0=0x69 in [7:0].
  - Required: bytes_valid_o 10 clocks after acceptance, bytes_o = plaintext 00112233445566778899aabbccddeeff (byte 0=0x00 in [7:0]).
- Round trip with Encrypt_AES_ECB:
  - Share the same key, encrypt the 8 blocks of text.hex, and feed each bytes_o into this block.
  - Stimulus: process_start_i held high with data advanced only on acceptance.
  - Required: 8 valid pulses, 11 cycles apart, each equal to the original text block.
- Enable stall: drop enable_i for 3 cycles at round 5 -> busy_o stays 1, valid is delayed by exactly 3 cycles, and the C.1 result is unchanged.
- Reset mid-operation: assert rst_n_i 4 cycles after acceptance -> outputs go to the reset values asynchronously, no valid pulse, and KEYGEN repeats (busy 10 cycles).
- Ignore while disabled: process_start_i=1 with enable_i=0 in IDLE for 20 cycles -> no acceptance, busy_o=0, bytes_valid_o=0.
